alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Pipeline register and forwarding stage directly upstream of the ALU; it produces the ALU's ina, inb and ALUcontrol.
- Captures decoded operands from the decode stage under a valid/ready handshake.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB result buses.
- Holds a single entry; while that entry is stalled it snoops write-back so the held operands never go stale.

Parameters:
WIDTH, 32, datapath width (ALU operand width)
RA_W, 5, register address width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  decode stage presents an instruction
in_ready  out  1  stage can accept this cycle
flush  in  1  kill held/incoming instruction (branch taken)
rs_addr  in  RA_W  source register A index
rt_addr  in  RA_W  source register B index
rs_data  in  WIDTH  register file read A
rt_data  in  WIDTH  register file read B
imm  in  WIDTH  sign-extended immediate
alu_src  in  1  1: inb = imm, 0: inb = forwarded rt
alu_ctrl_in  in  3  ALU operation code (000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT)
rd_in  in  RA_W  destination register
reg_write_in  in  1  instruction writes rd
exm_wr  in  1  EX/MEM result will be written
exm_rd  in  RA_W  EX/MEM destination
exm_data  in  WIDTH  EX/MEM result
mwb_wr  in  1  MEM/WB write-back enable
mwb_rd  in  RA_W  MEM/WB destination
mwb_data  in  WIDTH  MEM/WB write data
out_valid  out  1  ina/inb/ctrl valid to ALU
out_ready  in  1  downstream consumes this cycle
ina  out  WIDTH  ALU operand A
inb  out  WIDTH  ALU operand B
store_data  out  WIDTH  forwarded rt value (for sw), independent of alu_src
alu_ctrl  out  3  registered ALU op
rd_out  out  RA_W  registered destination
reg_write_out  out  1  registered write enable (0 whenever out_valid = 0)

Behaviour:
- Reset (rst_n = 0 at an edge): out_valid, ina, inb, store_data, alu_ctrl, rd_out and reg_write_out all 0; held rs/rt indices and alu_src cleared. Reset overrides flush and load.
- in_ready = !out_valid || out_ready. It is combinational, and flush does not gate it.
- Load: when in_valid && in_ready && !flush, capture at the edge; out_valid = 1 next cycle. Latency is 1 cycle.
- Forwarding per source x in {rs, rt}, evaluated at capture:
  - if exm_wr && exm_rd == x && x != 0, use exm_data;
  - else if mwb_wr && mwb_rd == x && x != 0, use mwb_data;
  - else use the regfile data.
  - EX/MEM has priority over MEM/WB.
- Operand assignment: ina = fwd(rs). store_data = fwd(rt). inb = imm if alu_src, else fwd(rt).
- Register 0 is never forwarded; its value is the regfile data as presented.
- Hold: if out_valid && !out_ready, every output is stable, with one exception, snoop:
  - if mwb_wr && mwb_rd != 0 and mwb_rd equals the held rs, ina ← mwb_data;
  - if it equals the held rt, store_data ← mwb_data, and inb ← mwb_data when held alu_src = 0.
  - The snoop uses MEM/WB only.
- Drain: if out_valid && out_ready && no load, out_valid ← 0 and reg_write_out ← 0. Data registers may keep stale values.
- Back-to-back: consume and load in the same cycle sustains 1 instruction/cycle with no bubble.
- Flush: at the edge, out_valid ← 0 and reg_write_out ← 0, and any incoming in_valid that cycle is discarded. Flush has priority over both load and hold.
- Operand widths are passed through unmodified; the stage performs no arithmetic.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with in_valid = 1 -> out_valid = 0, ina = inb = 0, reg_write_out = 0. Then release with an ADD, rs data 5, rt data 7, alu_src = 0 -> next cycle out_valid = 1, ina = 5, inb = 7, alu_ctrl = 010.
- Forward priority: rs = 3, exm_wr = 1, exm_rd = 3, exm_data = 0xAA, and mwb_rd = 3, mwb_data = 0xBB -> ina = 0xAA. Repeat with exm_wr = 0 -> ina = 0xBB. Repeat with rs = 0 and both matching -> ina = rs_data.
- Immediate: alu_src = 1, imm = 0xFFFFFFFC, rt forwarded 0x10 -> inb = 0xFFFFFFFC, store_data = 0x10.
- Stall snoop: load SUB with rt = 4, alu_src = 0. Hold out_ready = 0 for 3 cycles; in cycle 2 pulse mwb_wr with mwb_rd = 4, mwb_data = 0x55 -> inb = store_data = 0x55, in_ready = 0 throughout, other outputs unchanged.
- Throughput: out_ready = 1 and in_valid = 1 for 4 consecutive instructions -> 4 consecutive out_valid cycles in order, no bubble.
- Flush: flush = 1 while stalled with in_valid = 1 -> next cycle out_valid = 0, reg_write_out = 0, and the incoming instruction never appears at the output.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Bundle of decode-side, bypass-bus and ALU-side signals around the ALU operand stage.
// The master drives decode/bypass inputs and out_ready; the slave is the stage itself.
interface alu_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [RA_W-1:0]  rs_addr;
  logic [RA_W-1:0]  rt_addr;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm;
  logic             alu_src;
  logic [2:0]       alu_ctrl_in;
  logic [RA_W-1:0]  rd_in;
  logic             reg_write_in;
  logic             exm_wr;
  logic [RA_W-1:0]  exm_rd;
  logic [WIDTH-1:0] exm_data;
  logic             mwb_wr;
  logic [RA_W-1:0]  mwb_rd;
  logic [WIDTH-1:0] mwb_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic [WIDTH-1:0] store_data;
  logic [2:0]       alu_ctrl;
  logic [RA_W-1:0]  rd_out;
  logic             reg_write_out;

  modport master (
    output in_valid, flush, rs_addr, rt_addr, rs_data, rt_data, imm, alu_src,
           alu_ctrl_in, rd_in, reg_write_in, exm_wr, exm_rd, exm_data,
           mwb_wr, mwb_rd, mwb_data, out_ready,
    input  in_ready, out_valid, ina, inb, store_data, alu_ctrl, rd_out, reg_write_out
  );

  modport slave (
    input  in_valid, flush, rs_addr, rt_addr, rs_data, rt_data, imm, alu_src,
           alu_ctrl_in, rd_in, reg_write_in, exm_wr, exm_rd, exm_data,
           mwb_wr, mwb_rd, mwb_data, out_ready,
    output in_ready, out_valid, ina, inb, store_data, alu_ctrl, rd_out, reg_write_out
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Single-entry operand register in front of the ALU: forwards from EX/MEM and MEM/WB
// at capture, and snoops MEM/WB write-back while the held entry is stalled.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input logic           clk,
  input logic           rst_n,
  alu_operand_stage_if.slave bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] ina_q;
  logic [WIDTH-1:0] inb_q;
  logic [WIDTH-1:0] store_q;
  logic [2:0]       alu_ctrl_q;
  logic [RA_W-1:0]  rd_q;
  logic             reg_write_q;
  logic [RA_W-1:0]  rs_q;
  logic [RA_W-1:0]  rt_q;
  logic             alu_src_q;

  logic             load;
  logic             hold;
  logic             consume;
  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;
  logic             snoop_rs;
  logic             snoop_rt;

  // Handshake: a transfer happens on an edge where valid && ready on that side.
  // Upstream is accepted whenever the entry is empty or being drained this cycle;
  // flush never lowers in_ready, it only discards what would have been captured.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign load    = bus.in_valid && bus.in_ready && !bus.flush;
  assign hold    = out_valid_q && !bus.out_ready;
  assign consume = out_valid_q && bus.out_ready;

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never bypassed.
  always_comb begin
    rs_fwd = bus.rs_data;
    if (bus.exm_wr && bus.exm_rd == bus.rs_addr && bus.rs_addr != '0)
      rs_fwd = bus.exm_data;
    else if (bus.mwb_wr && bus.mwb_rd == bus.rs_addr && bus.rs_addr != '0)
      rs_fwd = bus.mwb_data;

    rt_fwd = bus.rt_data;
    if (bus.exm_wr && bus.exm_rd == bus.rt_addr && bus.rt_addr != '0)
      rt_fwd = bus.exm_data;
    else if (bus.mwb_wr && bus.mwb_rd == bus.rt_addr && bus.rt_addr != '0)
      rt_fwd = bus.mwb_data;
  end

  assign snoop_rs = bus.mwb_wr && bus.mwb_rd != '0 && bus.mwb_rd == rs_q;
  assign snoop_rt = bus.mwb_wr && bus.mwb_rd != '0 && bus.mwb_rd == rt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ina_q       <= '0;
      inb_q       <= '0;
      store_q     <= '0;
      alu_ctrl_q  <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      alu_src_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      ina_q       <= rs_fwd;
      inb_q       <= bus.alu_src ? bus.imm : rt_fwd;
      store_q     <= rt_fwd;
      alu_ctrl_q  <= bus.alu_ctrl_in;
      rd_q        <= bus.rd_in;
      reg_write_q <= bus.reg_write_in;
      rs_q        <= bus.rs_addr;
      rt_q        <= bus.rt_addr;
      alu_src_q   <= bus.alu_src;
    end else if (hold) begin
      // A stalled entry must track write-backs that retire while it waits.
      if (snoop_rs) ina_q <= bus.mwb_data;
      if (snoop_rt) begin
        store_q <= bus.mwb_data;
        if (!alu_src_q) inb_q <= bus.mwb_data;
      end
    end else if (consume) begin
      out_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.ina           = ina_q;
  assign bus.inb           = inb_q;
  assign bus.store_data    = store_q;
  assign bus.alu_ctrl      = alu_ctrl_q;
  assign bus.rd_out        = rd_q;
  assign bus.reg_write_out = reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: vector table, stall/snoop and flush sequences,
// with a queue of expected ALU-side outputs popped on every consumed entry.
module tb_alu_operand_stage;

  localparam int W  = 32;
  localparam int RA = 5;
  localparam int EW = 3 * W + 3 + RA + 1;
  localparam int NV = 7;

  typedef struct {
    logic [RA-1:0] rs_addr, rt_addr, rd_in, exm_rd, mwb_rd;
    logic [W-1:0]  rs_data, rt_data, imm, exm_data, mwb_data;
    logic          alu_src, reg_write_in, exm_wr, mwb_wr;
    logic [2:0]    alu_ctrl_in;
    logic [W-1:0]  e_ina, e_inb, e_store;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  alu_operand_stage_if #(.WIDTH(W), .RA_W(RA)) bus ();
  alu_operand_stage #(.WIDTH(W), .RA_W(RA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [RA-1:0] rs, input logic [W-1:0] rsd, input logic [RA-1:0] rt, input logic [W-1:0] rtd,
    input logic src, input logic [W-1:0] imm, input logic [2:0] ctrl, input logic [RA-1:0] rd, input logic rw,
    input logic ew, input logic [RA-1:0] erd, input logic [W-1:0] ed,
    input logic mw, input logic [RA-1:0] mrd, input logic [W-1:0] md,
    input logic [W-1:0] e_ina, input logic [W-1:0] e_inb, input logic [W-1:0] e_store);
    vec_t v;
    v.rs_addr = rs; v.rs_data = rsd; v.rt_addr = rt; v.rt_data = rtd;
    v.alu_src = src; v.imm = imm; v.alu_ctrl_in = ctrl; v.rd_in = rd; v.reg_write_in = rw;
    v.exm_wr = ew; v.exm_rd = erd; v.exm_data = ed;
    v.mwb_wr = mw; v.mwb_rd = mrd; v.mwb_data = md;
    v.e_ina = e_ina; v.e_inb = e_inb; v.e_store = e_store;
    return v;
  endfunction

  function automatic logic [EW-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] s, input logic [2:0] c,
                                         input logic [RA-1:0] rd, input logic rw);
    return {a, b, s, c, rd, rw};
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    bus.rs_addr = '0; bus.rt_addr = '0; bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0;
    bus.alu_src = 1'b0; bus.alu_ctrl_in = '0; bus.rd_in = '0; bus.reg_write_in = 1'b0;
    bus.exm_wr = 1'b0; bus.exm_rd = '0; bus.exm_data = '0;
    bus.mwb_wr = 1'b0; bus.mwb_rd = '0; bus.mwb_data = '0;
  endtask

  task automatic apply(input vec_t v);
    bus.in_valid = 1'b1;
    bus.rs_addr = v.rs_addr; bus.rt_addr = v.rt_addr; bus.rs_data = v.rs_data; bus.rt_data = v.rt_data;
    bus.imm = v.imm; bus.alu_src = v.alu_src; bus.alu_ctrl_in = v.alu_ctrl_in;
    bus.rd_in = v.rd_in; bus.reg_write_in = v.reg_write_in;
    bus.exm_wr = v.exm_wr; bus.exm_rd = v.exm_rd; bus.exm_data = v.exm_data;
    bus.mwb_wr = v.mwb_wr; bus.mwb_rd = v.mwb_rd; bus.mwb_data = v.mwb_data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consumed entry must match the oldest expected record.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got rd=%0d ina=%h with no entry expected", bus.rd_out, bus.ina);
      end else begin
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        e = exp_q.pop_front();
        g = pack(bus.ina, bus.inb, bus.store_data, bus.alu_ctrl, bus.rd_out, bus.reg_write_out);
        if (g !== e) begin
          n_fail++;
          $display("FAIL sb_entry: got %h expected %h", g, e);
        end
      end
    end
  end

  initial begin
    vec_t v;
    vecs[0] = mk(5'd3, 32'h11, 5'd6, 32'h66, 1'b0, 32'h0, 3'b010, 5'd8, 1'b1,
                 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA, 32'h66, 32'h66);
    vecs[1] = mk(5'd3, 32'h11, 5'd6, 32'h66, 1'b0, 32'h0, 3'b010, 5'd8, 1'b1,
                 1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hBB, 32'h66, 32'h66);
    vecs[2] = mk(5'd0, 32'h123, 5'd6, 32'h66, 1'b0, 32'h0, 3'b001, 5'd9, 1'b1,
                 1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'h123, 32'h66, 32'h66);
    vecs[3] = mk(5'd1, 32'h1, 5'd4, 32'h99, 1'b1, 32'hFFFFFFFC, 3'b011, 5'd2, 1'b0,
                 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h10, 32'h1, 32'hFFFFFFFC, 32'h10);
    vecs[4] = mk(5'd7, 32'h7, 5'd9, 32'h9, 1'b0, 32'h0, 3'b111, 5'd10, 1'b1,
                 1'b1, 5'd9, 32'h999, 1'b1, 5'd7, 32'h777, 32'h777, 32'h999, 32'h999);
    vecs[5] = mk(5'd6, 32'hCAFE, 5'd7, 32'hBEEF, 1'b0, 32'h0, 3'b001, 5'd11, 1'b1,
                 1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd12, 32'hF00D, 32'hCAFE, 32'hBEEF, 32'hBEEF);
    vecs[6] = mk(5'd2, 32'h2, 5'd0, 32'h5A5A, 1'b0, 32'h0, 3'b000, 5'd13, 1'b1,
                 1'b1, 5'd0, 32'hAA, 1'b0, 5'd0, 32'h0, 32'h2, 32'h5A5A, 32'h5A5A);

    // Reset with an ADD already presented; it loads on the first edge after release.
    rst_n = 1'b0;
    idle_inputs();
    bus.out_ready = 1'b1;
    apply(mk(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'h0, 3'b010, 5'd3, 1'b1,
             1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 32'd7));
    repeat (2) step();
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_ina", bus.ina, 32'd0);
    check("rst_inb", bus.inb, 32'd0);
    check("rst_store", bus.store_data, 32'd0);
    check("rst_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
    check("rst_reg_write", {31'b0, bus.reg_write_out}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    exp_q.push_back(pack(32'd5, 32'd7, 32'd7, 3'b010, 5'd3, 1'b1));
    step();
    check("add_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("add_ina", bus.ina, 32'd5);
    check("add_inb", bus.inb, 32'd7);
    check("add_ctrl", {29'b0, bus.alu_ctrl}, 32'd2);

    // Vector table applied back-to-back with the consumer always ready.
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      exp_q.push_back(pack(vecs[i].e_ina, vecs[i].e_inb, vecs[i].e_store,
                           vecs[i].alu_ctrl_in, vecs[i].rd_in, vecs[i].reg_write_in));
      step();
      check("tbl_out_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    idle_inputs();
    step();
    check("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("drain_reg_write", {31'b0, bus.reg_write_out}, 32'd0);

    // Four random hazard-free instructions must stream with no bubble.
    for (int i = 0; i < 4; i++) begin
      v = mk(5'($urandom_range(1, 31)), 32'($urandom), 5'($urandom_range(1, 31)), 32'($urandom),
             1'b0, 32'h0, 3'b010, 5'($urandom_range(0, 31)), 1'b1,
             1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      apply(v);
      exp_q.push_back(pack(v.rs_data, v.rt_data, v.rt_data, 3'b010, v.rd_in, 1'b1));
      step();
      check("thru_out_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    idle_inputs();
    step();

    // Stall snoop: MEM/WB write to held rt updates inb and store_data; EX/MEM does not.
    apply(mk(5'd2, 32'h22, 5'd4, 32'h44, 1'b0, 32'h0, 3'b011, 5'd3, 1'b1,
             1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h22, 32'h55, 32'h55));
    bus.out_ready = 1'b0;
    exp_q.push_back(pack(32'h22, 32'h55, 32'h55, 3'b011, 5'd3, 1'b1));
    step();
    bus.in_valid = 1'b0;
    check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("stall_in_ready1", {31'b0, bus.in_ready}, 32'd0);
    check("stall_inb_pre", bus.inb, 32'h44);
    bus.exm_wr = 1'b1; bus.exm_rd = 5'd4; bus.exm_data = 32'hEE;
    step();
    check("stall_exm_ignored", bus.inb, 32'h44);
    check("stall_in_ready2", {31'b0, bus.in_ready}, 32'd0);
    bus.exm_wr = 1'b0;
    bus.mwb_wr = 1'b1; bus.mwb_rd = 5'd4; bus.mwb_data = 32'h55;
    step();
    bus.mwb_wr = 1'b0;
    check("snoop_inb", bus.inb, 32'h55);
    check("snoop_store", bus.store_data, 32'h55);
    check("snoop_ina_kept", bus.ina, 32'h22);
    check("snoop_ctrl_kept", {29'b0, bus.alu_ctrl}, 32'd3);
    check("snoop_rd_kept", {27'b0, bus.rd_out}, 32'd3);
    check("stall_in_ready3", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("stall_release", {31'b0, bus.out_valid}, 32'd0);

    // Immediate entry stalled: rt snoop reaches store_data only, rs snoop reaches ina; then flush.
    apply(mk(5'd2, 32'h22, 5'd4, 32'h44, 1'b1, 32'h1234, 3'b010, 5'd5, 1'b1,
             1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.mwb_wr = 1'b1; bus.mwb_rd = 5'd4; bus.mwb_data = 32'h5A;
    step();
    check("imm_snoop_store", bus.store_data, 32'h5A);
    check("imm_snoop_inb_kept", bus.inb, 32'h1234);
    bus.mwb_rd = 5'd2; bus.mwb_data = 32'h6B;
    step();
    bus.mwb_wr = 1'b0;
    check("rs_snoop_ina", bus.ina, 32'h6B);
    check("rs_snoop_store_kept", bus.store_data, 32'h5A);
    apply(mk(5'd8, 32'h88, 5'd9, 32'h99, 1'b0, 32'h0, 3'b001, 5'd20, 1'b1,
             1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    bus.flush = 1'b1;
    check("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("flush_reg_write", {31'b0, bus.reg_write_out}, 32'd0);
    bus.out_ready = 1'b1;

    // Flush while empty and ready: the incoming instruction must be discarded.
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    check("flush_empty_in_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_empty_out_valid", {31'b0, bus.out_valid}, 32'd0);
    repeat (3) begin
      step();
      check("flush_no_output", {31'b0, bus.out_valid}, 32'd0);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("sb_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
